// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator that runs IR/DR scans from Run-Test/Idle and returns captured TDO.
// Define JTAG_HOST_TRST_EN to add an active-low jtag_trst_no output asserted during TAP reset.
module jtag_host #(
   parameter int ClkDiv = 2,
   parameter int MaxLen = 32,
   parameter int LenW   = $clog2(MaxLen + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_ir_i,
   input  logic [LenW-1:0]   cmd_len_i,
   input  logic [MaxLen-1:0] cmd_data_i,
   input  logic              trst_req_i,
   output logic              rsp_valid_o,
   output logic [MaxLen-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   output logic              jtag_tck_o,
   output logic              jtag_tms_o,
   output logic              jtag_td_o,
   input  logic              jtag_td_i
`ifdef JTAG_HOST_TRST_EN
   ,
   output logic              jtag_trst_no
`endif
);
   localparam int CW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
   localparam int SW = $clog2(MaxLen + 7);
   localparam int IW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
   typedef enum logic [1:0] {TLR_SEQ, IDLE, SCAN, DONE} state_t;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [SW-1:0]     step, nstep, pre, len_w, cdiff, ndiff;
   logic              ir_q, ready_q, tick, rise, fall, cap_shift, nxt_shift, tms_n, td_n, len_ok;
   logic [LenW-1:0]   len_q;
   logic [MaxLen-1:0] data_q;
   // step counts completed TCK cycles of the current sequence; nstep is the one being set up
   always_comb begin
      tick      = cnt == CW'(ClkDiv - 1);
      rise      = tick && !jtag_tck_o;
      fall      = tick && jtag_tck_o;
      len_w     = SW'(len_q);
      pre       = ir_q ? SW'(4) : SW'(3);
      nstep     = step + SW'(1);
      cdiff     = step - pre;
      ndiff     = nstep - pre;
      cap_shift = step >= pre && cdiff < len_w;
      nxt_shift = nstep >= pre && ndiff < len_w;
      tms_n     = (ir_q && nstep == SW'(1)) || nstep == pre + len_w - SW'(1) || nstep == pre + len_w;
      td_n      = nxt_shift ? data_q[ndiff[IW-1:0]] : 1'b0;
      len_ok    = cmd_len_i != '0 && cmd_len_i <= LenW'(MaxLen);
   end
   assign cmd_ready_o = ready_q && !trst_req_i;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= TLR_SEQ;
         cnt         <= '0;
         step        <= '0;
         ir_q        <= 1'b0;
         len_q       <= '0;
         data_q      <= '0;
         ready_q     <= 1'b0;
         busy_o      <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_data_o  <= '0;
         jtag_tck_o  <= 1'b0;
         jtag_tms_o  <= 1'b1;
         jtag_td_o   <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            TLR_SEQ, SCAN: begin
               if (tick) begin
                  cnt        <= '0;
                  jtag_tck_o <= !jtag_tck_o;
                  if (rise && state == SCAN && cap_shift) rsp_data_o[cdiff[IW-1:0]] <= jtag_td_i;
                  if (fall) begin
                     step <= nstep;
                     if (state == TLR_SEQ) begin
                        jtag_tms_o <= nstep < SW'(5);
                        if (nstep == SW'(6)) begin
                           state   <= IDLE;
                           ready_q <= 1'b1;
                           busy_o  <= 1'b0;
                        end
                     end else begin
                        jtag_tms_o <= tms_n;
                        jtag_td_o  <= td_n;
                        if (nstep == pre + len_w + SW'(2)) begin
                           state       <= DONE;
                           rsp_valid_o <= 1'b1;
                        end
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            IDLE: begin
               if (trst_req_i) begin
                  state      <= TLR_SEQ;
                  ready_q    <= 1'b0;
                  busy_o     <= 1'b1;
                  step       <= '0;
                  cnt        <= '0;
                  jtag_tms_o <= 1'b1;
               end else if (cmd_valid_i) begin
                  ready_q    <= 1'b0;
                  busy_o     <= 1'b1;
                  ir_q       <= cmd_ir_i;
                  len_q      <= cmd_len_i;
                  data_q     <= cmd_data_i;
                  rsp_data_o <= '0;
                  rsp_err_o  <= !len_ok;
                  step       <= '0;
                  cnt        <= '0;
                  // an illegal length is answered immediately without touching the TAP
                  state       <= len_ok ? SCAN : DONE;
                  rsp_valid_o <= !len_ok;
                  jtag_tms_o  <= len_ok;
               end
            end
            DONE: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end
`ifdef JTAG_HOST_TRST_EN
   // TRST is held low for the first two TCK cycles of every TAP reset walk
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) jtag_trst_no <= 1'b0;
      else if (state == IDLE && trst_req_i) jtag_trst_no <= 1'b0;
      else if (state == TLR_SEQ && fall && nstep == SW'(2)) jtag_trst_no <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: directed and random scans against a 1149.1 target model with arithmetic expectations.
module tb_jtag_host;
   localparam int ClkDiv = 2;
   localparam int MaxLen = 32;
   localparam int LenW   = $clog2(MaxLen + 1);
   typedef enum int {T_TLR, T_RTI, T_SDS, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
                     T_SIS, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_t;
   logic clk = 0, rst_n = 1, cmd_valid = 0, cmd_ir = 0, trst_req = 0, td_i = 0;
   logic [LenW-1:0] cmd_len = '0;
   logic [MaxLen-1:0] cmd_data = '0, rsp_data;
   logic cmd_ready, rsp_valid, rsp_err, busy, tck, tms, td_o;
`ifdef JTAG_HOST_TRST_EN
   logic trst_n;
`endif
   int total = 0, bad = 0, vcnt = 0, hi_cnt = 0;
   logic prev_tms = 0, prev_td = 0, have_prev = 0;
   bit q_tms[$], q_tdi[$];
   tap_t tap = T_TLR;
   logic [4:0] sr_ir = '0;
   logic [31:0] sr_dr = '0, dr_reg = 32'h1234_5678, exp_dr = 32'h1234_5678;

   jtag_host #(.ClkDiv(ClkDiv), .MaxLen(MaxLen)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_ir_i(cmd_ir), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data), .trst_req_i(trst_req),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
      .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_td_o(td_o), .jtag_td_i(td_i)
`ifdef JTAG_HOST_TRST_EN
      , .jtag_trst_no(trst_n)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic tap_t nxt(input tap_t s, input logic m);
      case (s)
         T_TLR:  return m ? T_TLR  : T_RTI;
         T_RTI:  return m ? T_SDS  : T_RTI;
         T_SDS:  return m ? T_SIS  : T_CDR;
         T_CDR:  return m ? T_E1DR : T_SHDR;
         T_SHDR: return m ? T_E1DR : T_SHDR;
         T_E1DR: return m ? T_UDR  : T_PDR;
         T_PDR:  return m ? T_E2DR : T_PDR;
         T_E2DR: return m ? T_UDR  : T_SHDR;
         T_UDR:  return m ? T_SDS  : T_RTI;
         T_SIS:  return m ? T_TLR  : T_CIR;
         T_CIR:  return m ? T_E1IR : T_SHIR;
         T_SHIR: return m ? T_E1IR : T_SHIR;
         T_E1IR: return m ? T_UIR  : T_PIR;
         T_PIR:  return m ? T_E2IR : T_PIR;
         T_E2IR: return m ? T_UIR  : T_SHIR;
         default: return m ? T_SDS : T_RTI;
      endcase
   endfunction

   // target TAP: IR captures 5'b00001, DR is a 32-bit register updated on Update-DR
   always @(posedge tck) begin
      q_tms.push_back(tms);
      q_tdi.push_back(td_o);
      case (tap)
         T_CIR:  sr_ir = 5'b00001;
         T_CDR:  sr_dr = dr_reg;
         T_SHIR: sr_ir = {td_o, sr_ir[4:1]};
         T_SHDR: sr_dr = {td_o, sr_dr[31:1]};
         T_UDR:  dr_reg = sr_dr;
         default: ;
      endcase
      tap = nxt(tap, tms);
   end
   always @(negedge tck) td_i = (tap == T_SHIR) ? sr_ir[0] : (tap == T_SHDR) ? sr_dr[0] : 1'b0;

   always @(negedge clk) begin
      if (rsp_valid) vcnt++;
      if (!rst_n) begin
         hi_cnt = 0;
         have_prev = 0;
      end else begin
         if (tck) hi_cnt++;
         else if (hi_cnt != 0) begin
            chk("tck_high_phase", hi_cnt, ClkDiv);
            hi_cnt = 0;
         end
         if (tck && have_prev) chk("tms_td_stable_hi", {prev_tms, prev_td}, {tms, td_o});
         prev_tms = tms;
         prev_td = td_o;
         have_prev = 1;
      end
   end

   function automatic logic [63:0] mask(input int l);
      return (l >= 64) ? '1 : (64'h1 << l) - 64'h1;
   endfunction

   function automatic logic [63:0] exp_tms(input bit ir, input int l);
      bit s[$];
      logic [63:0] v = '0;
      s = ir ? '{1, 1, 0, 0} : '{1, 0, 0};
      for (int i = 0; i < l - 1; i++) s.push_back(0);
      s.push_back(1);
      s.push_back(1);
      s.push_back(0);
      for (int i = 0; i < s.size(); i++) v[i] = s[i];
      return v;
   endfunction

   task automatic check_seq(input string tag, input int n, input logic [63:0] tms_e, input logic [63:0] tdi_e);
      logic [63:0] tv = '0, dv = '0;
      for (int i = 0; i < q_tms.size() && i < 64; i++) begin
         tv[i] = q_tms[i];
         dv[i] = q_tdi[i];
      end
      chk({tag, "_tck_cycles"}, q_tms.size(), n);
      chk({tag, "_tms"}, tv, tms_e);
      chk({tag, "_tdi"}, dv, tdi_e);
   endtask

   task automatic do_cmd(input bit ir, input int l, input logic [31:0] d, input bit pre_trst);
      logic [63:0] comb, expd, dm;
      bit legal;
      int n, vc0, p;
      logic tb4;
      legal = l >= 1 && l <= MaxLen;
      p = ir ? 4 : 3;
      dm = {32'h0, d} & mask(l);
      comb = (ir ? 64'h1 : {32'h0, exp_dr}) | (dm << (ir ? 5 : 32));
      expd = legal ? comb & mask(l) : 64'h0;
      @(negedge clk);
      cmd_valid = 1;
      cmd_ir = ir;
      cmd_len = LenW'(l);
      cmd_data = d;
      if (pre_trst) begin
         trst_req = 1;
         q_tms.delete();
         q_tdi.delete();
         #1 chk("trst_wins_ready", cmd_ready, 0);
         @(negedge clk);
         trst_req = 0;
         chk("trst_busy", busy, 1);
      end
      n = 0;
      while (!cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready", cmd_ready, 1);
      if (pre_trst) check_seq("pre_tlr", 6, 64'h1f, 64'h0);
      q_tms.delete();
      q_tdi.delete();
      vc0 = vcnt;
      @(negedge clk);
      cmd_valid = 0;
      cmd_data = $urandom;
      n = 0;
      tb4 = 0;
      while (!rsp_valid && n < 2000) begin
         tb4 = tck;
         @(negedge clk);
         n++;
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, !legal);
      chk("rsp_data", rsp_data, expd);
      if (legal) begin
         chk("last_tck_high", tb4, 1);
         check_seq(ir ? "ir" : "dr", l + p + 2, exp_tms(ir, l), dm << p);
      end else begin
         chk("err_latency", n, 0);
         check_seq("err", 0, 64'h0, 64'h0);
      end
      chk("tap_rti", tap == T_RTI, 1);
      if (legal && !ir) exp_dr = comb[l +: 32];
      @(negedge clk);
      chk("rsp_pulse", rsp_valid, 0);
      chk("ready_after", cmd_ready, 1);
      chk("busy_after", busy, 0);
      chk("rsp_hold", rsp_data, expd);
      chk("rsp_count", vcnt - vc0, 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_tck"}, tck, 0);
      chk({tag, "_tms"}, tms, 1);
      chk({tag, "_td"}, td_o, 0);
      chk({tag, "_ready"}, cmd_ready, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
   endtask

   task automatic release_and_tlr(input string tag);
      int n, vc0;
      q_tms.delete();
      q_tdi.delete();
      vc0 = vcnt;
      rst_n = 1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!cmd_ready && n < 200);
      chk({tag, "_clks"}, n, 24);
      check_seq(tag, 6, 64'h1f, 64'h0);
      chk({tag, "_tap_rti"}, tap == T_RTI, 1);
      chk({tag, "_no_rsp"}, vcnt - vc0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, vc0;
      #2 rst_n = 0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      release_and_tlr("tlr");
      do_cmd(1, 5, 32'b10110, 0);
      do_cmd(0, 32, 32'hDEAD_BEEF, 0);
      do_cmd(0, 32, 32'h0, 0);
      do_cmd(0, 0, $urandom, 0);
      do_cmd(1, 33, $urandom, 0);
      for (int i = 0; i < 8; i++) begin
         bit ir_r;
         int l_r;
         ir_r = 1'($urandom_range(0, 1));
         l_r = int'($urandom_range(1, 32));
         do_cmd(ir_r, l_r, $urandom, 0);
      end
      do_cmd(0, 8, 32'hA5, 1);
      fork
         do_cmd(0, 16, 32'h0000_C3A5, 0);
         begin
            repeat (20) @(negedge clk);
            trst_req = 1;
            @(negedge clk);
            trst_req = 0;
         end
      join
      // reset while shifting bit 10 of a DR scan
      @(negedge clk);
      cmd_valid = 1;
      cmd_ir = 0;
      cmd_len = LenW'(32);
      cmd_data = $urandom;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      q_tms.delete();
      q_tdi.delete();
      vc0 = vcnt;
      @(negedge clk);
      cmd_valid = 0;
      n = 0;
      while (q_tms.size() < 14 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("mid_scan_reached", q_tms.size(), 14);
      rst_n = 0;
      #1 check_reset("mid_reset");
      chk("mid_no_rsp", vcnt - vc0, 0);
      repeat (3) @(negedge clk);
      release_and_tlr("re_tlr");
      do_cmd(1, 7, $urandom, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jtag_host.md
Name: jtag_host

Overview:
- JTAG initiator. Drives TCK/TMS/TDI toward a JTAG target TAP and samples TDO.
- Used as an on-chip or FPGA-bench debug probe, so an emulation top can be exercised without an external dongle.
- Accepts IR-scan and DR-scan commands over a valid/ready interface, runs the IEEE 1149.1 TAP walk from Run-Test/Idle and back, and returns the captured TDO bits.

Parameters:
- ClkDiv, 2: TCK half-period in clk_i cycles (>=1). One TCK period is 2*ClkDiv clk cycles.
- MaxLen, 32: maximum scan length in bits.
- LenW, $clog2(MaxLen+1): width of cmd_len_i.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_ir_i  in  1  1=IR scan, 0=DR scan
- cmd_len_i  in  LenW  scan length in bits
- cmd_data_i  in  MaxLen  TDI bits, LSB shifted first
- trst_req_i  in  1  request TAP reset sequence (level, sampled when idle)
- rsp_valid_o  out  1  one-cycle pulse, scan done
- rsp_data_o  out  MaxLen  captured TDO bits, LSB = first captured
- rsp_err_o  out  1  qualifies rsp_valid_o; illegal length
- busy_o  out  1  sequence in progress
- jtag_tck_o  out  1  TCK
- jtag_tms_o  out  1  TMS
- jtag_td_o  out  1  TDI to target
- jtag_td_i  in  1  TDO from target

Behaviour:
- Reset values: tck=0, tms=1, td_o=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_err=0, rsp_data=0.
- TCK generation:
  - Each TCK cycle is a low phase of ClkDiv clk cycles, then a high phase of ClkDiv clk cycles.
  - tms/td_o change only on the clk edge that drives tck 1->0, or at sequence start while tck=0.
  - jtag_td_i is captured on the clk edge that drives tck 0->1.
- FSM states: TLR_SEQ, IDLE, SCAN, DONE.
- TLR_SEQ:
  - Entered automatically after rst_ni deasserts, and from IDLE when trst_req_i=1.
  - Issues 6 TCK cycles with TMS=1,1,1,1,1,0, ending in Run-Test/Idle. TDI=0 throughout. No rsp_valid pulse.
- IDLE:
  - cmd_ready_o=1, busy_o=0, tck=0, tms=0.
  - If trst_req_i and cmd_valid_i are both high in the same cycle, trst_req_i wins and cmd_ready_o=0 that cycle.
- SCAN: all command fields are latched on accept. The TMS sequence per TCK cycle is:
  - IR scan: 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - Shift phase: len cycles with TMS=0 except the last, which has TMS=1 (to Exit1). TDI=data[i] on shift cycle i. The TDO sampled on the rising edge of shift cycle i goes into rsp_data[i].
  - Tail: 1, 0 (Update, then Idle).
  - Totals: IR = len+6 TCK cycles, DR = len+5. TDI=0 outside the shift phase.
- DONE:
  - rsp_valid_o pulses for one clk cycle, the cycle after the final TCK high phase ends.
  - rsp_data_o holds until the next accept. Bits [MaxLen-1:len] = 0.
  - Next state is IDLE.
- Illegal length (cmd_len_i==0 or >MaxLen):
  - The command is accepted with no TCK activity.
  - rsp_valid_o=1 and rsp_err_o=1 on the next cycle, with rsp_data_o=0.
- No backpressure on rsp. cmd_ready_o=0 whenever not in IDLE.
- trst_req_i is ignored while busy.
- Reset mid-scan: asynchronous return to the reset values, then a fresh TLR_SEQ.

Optional Feature:
- Macro: JTAG_HOST_TRST_EN.
- With the macro defined:
  - Adds output port jtag_trst_no (1 bit), reset value 0.
  - It is held 0 during the first 2 TCK cycles of every TLR_SEQ and is 1 otherwise.
- Without it: the port is absent; TAP reset uses the TMS sequence only.

Test Plan:
- Release rst_ni, ClkDiv=2 -> 6 TCK periods of 4 clk each with TMS=1,1,1,1,1,0; cmd_ready_o rises after the 24th clk; no rsp_valid.
- IR scan, len=5, data=5'b10110, target TDO loops back TDI (one-TCK delay, 1149.1 model with captured value 5'b00001) -> 11 TCK cycles; TMS=1,1,0,0,0,0,0,0,1,1,0; TDI on shift cycles =0,1,1,0,1; rsp_data=5'b00001, rsp_err=0.
- DR scan, len=32, data=32'hDEADBEEF, target DR captures 32'h1234_5678 -> 37 TCK cycles; rsp_data=32'h12345678; the next DR scan of 32'h0 returns 32'hDEADBEEF.
- cmd_len=0, then cmd_len=33 -> each yields a one-cycle rsp_valid with rsp_err=1, rsp_data=0, and tck stays 0.
- trst_req_i and cmd_valid_i asserted in the same IDLE cycle -> TLR sequence runs first, then the command is accepted; trst_req_i pulsed during a scan has no effect.
- rst_ni asserted at shift bit 10 of a DR scan -> outputs at reset values immediately; no rsp_valid; a full TLR sequence follows the release.
